// File: rtl/dtree_pkg.sv
// ---------------------------------------------------------------------------
// dtree_pkg : shared types and width helpers for the decision-tree walker.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dtree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Decoded node, fields widened to a fixed maximum so one type serves every
  // parameterisation; the packed table word uses only the bits it needs.
  typedef struct packed {
    logic        is_leaf;
    logic [15:0] feat_idx;
    logic [7:0]  shift;
    logic [31:0] thr;
    logic [15:0] left;
    logic [15:0] right;
  } node_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Word layout, MSB to LSB: is_leaf, feat_idx, shift, thr, left, right.
  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + clog2_min1(n_feat) + clog2_min1(feat_w) + feat_w + 2 * clog2_min1(n_nodes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dtree_node_ram.sv
// ---------------------------------------------------------------------------
// dtree_node_ram : node table, one synchronous write port, one async read port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dtree_node_ram #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 25,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: table contents survive rst.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/dtree_seq_eval.sv
// ---------------------------------------------------------------------------
// dtree_seq_eval : sequential decision-tree classifier, one node per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dtree_seq_eval
  import dtree_pkg::*;
#(
  parameter int N_FEAT        = 5,
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 5,
  parameter int N_NODES       = 32,
  parameter int MAX_DEPTH     = 15,
  parameter int DEFAULT_CLASS = 0,
  localparam int NODE_IDX_W   = clog2_min1(N_NODES),
  localparam int NODE_W       = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NODE_IDX_W-1:0]    cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata
);

  localparam int FIDX_W    = clog2_min1(N_FEAT);
  localparam int SH_W      = clog2_min1(FEAT_W);
  localparam int STEP_W    = clog2_min1(MAX_DEPTH + 1);
  localparam int RIGHT_LSB = 0;
  localparam int LEFT_LSB  = NODE_IDX_W;
  localparam int THR_LSB   = 2 * NODE_IDX_W;
  localparam int SH_LSB    = THR_LSB + FEAT_W;
  localparam int FIDX_LSB  = SH_LSB + SH_W;
  localparam int LEAF_BIT  = FIDX_LSB + FIDX_W;

  state_t                     state_q, state_d;
  logic [NODE_IDX_W-1:0]      ptr_q, ptr_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic                       err_q, err_d;

  logic [NODE_W-1:0]          w_word;
  node_t                      w_node;
  logic [FEAT_W-1:0]          w_feat;
  logic [FEAT_W-1:0]          w_shifted;
  logic                       w_go_left;
  logic [15:0]                w_child;
  logic                       w_bad;
  logic                       w_last;

  dtree_node_ram #(
    .DEPTH  (N_NODES),
    .WIDTH  (NODE_W),
    .ADDR_W (NODE_IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (cfg_we && (state_q == ST_IDLE)),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (ptr_q),
    .rdata_o (w_word)
  );

  always_comb begin
    w_node          = '0;
    w_node.is_leaf  = w_word[LEAF_BIT];
    w_node.feat_idx = 16'(w_word[FIDX_LSB +: FIDX_W]);
    w_node.shift    = 8'(w_word[SH_LSB +: SH_W]);
    w_node.thr      = 32'(w_word[THR_LSB +: FEAT_W]);
    w_node.left     = 16'(w_word[LEFT_LSB +: NODE_IDX_W]);
    w_node.right    = 16'(w_word[RIGHT_LSB +: NODE_IDX_W]);
  end

  always_comb begin
    w_feat = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (w_node.feat_idx == 16'(i)) begin
        w_feat = feat_q[i*FEAT_W +: FEAT_W];
      end
    end
  end

  assign w_shifted = w_feat >> w_node.shift;
  assign w_go_left = (32'(w_shifted) <= w_node.thr);
  assign w_child   = w_go_left ? w_node.left : w_node.right;
  assign w_bad     = (32'(w_node.feat_idx) >= 32'(N_FEAT)) || (32'(w_child) >= 32'(N_NODES));
  // The node being evaluated is the last one the step budget allows.
  assign w_last    = (step_q == STEP_W'(MAX_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          feat_d  = in_feat;
          ptr_d   = '0;
          step_d  = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (w_node.is_leaf) begin
          class_d = w_word[THR_LSB +: CLASS_W];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (w_bad || w_last) begin
          class_d = CLASS_W'(DEFAULT_CLASS);
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          ptr_d  = w_child[NODE_IDX_W-1:0];
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      step_q  <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_class = class_q;
  assign out_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dtree_seq_eval.sv
// ---------------------------------------------------------------------------
// tb_dtree_seq_eval : randomized and directed bench with a tree-walk model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dtree_seq_eval;

  localparam int N_FEAT    = 5;
  localparam int N_NODES   = 32;
  localparam int MAX_DEPTH = 15;
  localparam int DEF_CLASS = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic        out_err;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [24:0] cfg_wdata;

  always #5 clk = ~clk;

  dtree_seq_eval #(
    .DEFAULT_CLASS (DEF_CLASS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word layout: {is_leaf, feat_idx[2:0], shift[2:0], thr[7:0], left[4:0], right[4:0]}
  function automatic logic [24:0] mk_int(input int fi, input int sh, input int thr,
                                         input int l, input int r);
    return {1'b0, 3'(fi), 3'(sh), 8'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic logic [24:0] mk_leaf(input int cls);
    return {1'b1, 3'd0, 3'd0, 8'(cls), 5'd0, 5'd0};
  endfunction

  logic [24:0] tbl [N_NODES];

  // Walk the tree from the root; latency counts cycles from accept to result.
  function automatic void predict(input logic [39:0] f, output logic [4:0] cls,
                                  output logic err, output int lat);
    int          p;
    int          fi;
    int          nxt;
    logic [24:0] w;
    logic [7:0]  v;
    p   = 0;
    cls = 5'(DEF_CLASS);
    err = 1'b1;
    lat = MAX_DEPTH + 1;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      w = tbl[p];
      if (w[24]) begin
        cls = w[14:10];
        err = 1'b0;
        lat = d + 2;
        return;
      end
      fi = int'(w[23:21]);
      if (fi >= N_FEAT) begin
        lat = d + 2;
        return;
      end
      v   = f[fi*8 +: 8] >> w[20:18];
      nxt = (v <= w[17:10]) ? int'(w[9:5]) : int'(w[4:0]);
      if (nxt >= N_NODES) begin
        lat = d + 2;
        return;
      end
      p = nxt;
    end
  endfunction

  // Model state: 0 idle, 1 walking (m_cnt edges left), 2 result held.
  bit         mon_en    = 1'b0;
  int         m_state   = 0;
  int         m_cnt     = 0;
  logic [4:0] m_class   = '0;
  logic       m_err     = 1'b0;
  bit         m_justrst = 1'b1;

  always @(negedge clk) begin
    int pl;
    if (mon_en) begin
      check("in_ready", in_ready, m_state == 0);
      check("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
        check("out_class", out_class, m_class);
        check("out_err", out_err, m_err);
      end
      if (m_justrst) begin
        check("rst_class", out_class, 0);
        check("rst_err", out_err, 0);
      end
      m_justrst = 1'b0;
      if (rst) begin
        m_state   = 0;
        m_justrst = 1'b1;
      end else begin
        case (m_state)
          0: begin
            if (cfg_we) tbl[cfg_addr] = cfg_wdata;
            if (in_valid) begin
              predict(in_feat, m_class, m_err, pl);
              m_cnt   = pl - 1;
              m_state = 1;
            end
          end
          1: begin
            m_cnt--;
            if (m_cnt == 0) m_state = 2;
          end
          default: if (out_ready) m_state = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("idle_timeout", w < 50, 1);
  endtask

  task automatic cfg_write(input int a, input logic [24:0] d);
    wait_idle();
    cfg_we    = 1'b1;
    cfg_addr  = 5'(a);
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic run_vec(input logic [39:0] f, input int hold, input bit mid_cfg,
                         input bit acc_cfg, input int ca, input logic [24:0] cd,
                         output logic [4:0] cls, output logic err, output int lat);
    wait_idle();
    in_valid = 1'b1;
    in_feat  = f;
    if (acc_cfg) begin
      cfg_we    = 1'b1;
      cfg_addr  = 5'(ca);
      cfg_wdata = cd;
    end
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_feat  = {8'($urandom), 32'($urandom)};
    lat      = 1;
    while (!out_valid && lat < 100) begin
      if (mid_cfg && lat == 1) begin
        cfg_we    = 1'b1;
        cfg_addr  = 5'(ca);
        cfg_wdata = cd;
      end
      tick();
      cfg_we  = 1'b0;
      in_feat = {8'($urandom), 32'($urandom)};
      lat++;
    end
    check("result_timeout", lat < 100, 1);
    cls = out_class;
    err = out_err;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic load_chain();
    cfg_write(0,  mk_int(0, 0, 255, 10, 1));
    cfg_write(10, mk_int(1, 0, 255, 11, 1));
    cfg_write(11, mk_int(2, 0, 255, 12, 1));
    cfg_write(12, mk_int(3, 0, 255, 13, 1));
    cfg_write(13, mk_leaf(21));
  endtask

  initial begin
    logic [39:0] f;
    logic [4:0]  c;
    logic        e;
    int          l;
    logic [4:0]  pc;
    logic        pe;
    int          pl;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tick();
    mon_en = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_class", out_class, 0);
    check("reset_out_err", out_err, 0);
    rst = 1'b0;

    for (int i = 0; i < N_NODES; i++) cfg_write(i, mk_leaf(i));

    // Root splits on feature 4 >> 6 against 0; both children are leaves.
    cfg_write(0, mk_int(4, 6, 0, 1, 2));
    cfg_write(1, mk_leaf(7));
    cfg_write(2, mk_leaf(3));
    f = {8'h3F, 32'($urandom)};
    predict(f, pc, pe, pl);
    check("pin_3f_class", pc, 7);
    check("pin_3f_lat", pl, 3);
    run_vec(f, 0, 0, 0, 0, '0, c, e, l);
    check("split_3f_class", c, 7);
    check("split_3f_err", e, 0);
    check("split_3f_lat", l, 3);
    f = {8'h40, 32'($urandom)};
    run_vec(f, 1, 0, 0, 0, '0, c, e, l);
    check("split_40_class", c, 3);
    check("split_40_lat", l, 3);

    load_chain();
    f = {8'($urandom), 32'($urandom)};
    predict(f, pc, pe, pl);
    check("pin_chain_lat", pl, 6);
    run_vec(f, 5, 0, 0, 0, '0, c, e, l);
    check("chain_class", c, 21);
    check("chain_lat", l, 6);

    // Reset in the second walk cycle drops the result.
    wait_idle();
    in_valid = 1'b1;
    in_feat  = f;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_walk_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      check("rst_walk_no_valid", out_valid, 0);
      tick();
    end
    run_vec(f, 0, 0, 0, 0, '0, c, e, l);
    check("after_rst_class", c, 21);
    check("after_rst_lat", l, 6);

    // Write to node 0 during a walk is dropped; a later walk sees only later writes.
    run_vec(f, 0, 1, 0, 0, mk_leaf(30), c, e, l);
    check("midcfg_class", c, 21);
    check("midcfg_lat", l, 6);
    run_vec(f, 0, 0, 0, 0, '0, c, e, l);
    check("midcfg_next_class", c, 21);
    run_vec(f, 0, 0, 1, 0, mk_leaf(17), c, e, l);
    check("acc_cfg_class", c, 17);
    check("acc_cfg_lat", l, 2);

    cfg_write(0, mk_int(0, 0, 255, 0, 0));
    predict(f, pc, pe, pl);
    check("pin_loop_err", pe, 1);
    check("pin_loop_lat", pl, 16);
    run_vec(f, 2, 0, 0, 0, '0, c, e, l);
    check("loop_err", e, 1);
    check("loop_class", c, DEF_CLASS);
    check("loop_lat", l, 16);
    cfg_write(0, mk_int(6, 0, 0, 1, 2));
    run_vec(f, 0, 0, 0, 0, '0, c, e, l);
    check("badfeat_err", e, 1);
    check("badfeat_class", c, DEF_CLASS);
    check("badfeat_lat", l, 2);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_NODES; i++) begin
        if ($urandom_range(9) < 4) cfg_write(i, mk_leaf($urandom_range(31)));
        else cfg_write(i, mk_int($urandom_range(5), $urandom_range(7), $urandom_range(255),
                                 $urandom_range(31), $urandom_range(31)));
      end
      for (int v = 0; v < 15; v++) begin
        f = {8'($urandom), 32'($urandom)};
        run_vec(f, $urandom_range(3), $urandom_range(3) == 0, $urandom_range(4) == 0,
                $urandom_range(31), mk_leaf($urandom_range(31)), c, e, l);
        for (int g = $urandom_range(2); g > 0; g--) tick();
      end
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
